// File: rtl/srm_pkg.sv
// srm_pkg: shared widths, shift codes and operand-fetch FSM states for the Simple RISC Machine datapath
package srm_pkg;
    localparam int DATA_W    = 16;
    localparam int NREGS     = 8;
    localparam int REG_IDX_W = 3;
    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_t;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RD_A  = 2'b01,
        RD_B  = 2'b10,
        VALID = 2'b11
    } state_t;
endpackage

// File: rtl/operand_fetch_regfile.sv
// regfile: 8x16 register file, one write port, one combinational read port, sync clear
// ports: clk, reset, write/wnum/wdata (write port), rnum -> rdata (read port)
// OPERAND_FETCH_BYPASS_EN: read returns wdata when reading the register being written this cycle
module regfile import srm_pkg::*; (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic [REG_IDX_W-1:0] wnum,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] rnum,
    output logic [DATA_W-1:0]    rdata
);
    logic [DATA_W-1:0] mem [NREGS];
    always_ff @(posedge clk) begin
        if (reset)
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        else if (write)
            mem[wnum] <= wdata;
    end
`ifdef OPERAND_FETCH_BYPASS_EN
    assign rdata = (write && wnum == rnum) ? wdata : mem[rnum];
`else
    assign rdata = mem[rnum];
`endif
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads R[rn] then R[rm] into operands A/B with the shift code, valid/ready output
// ports: start/rn/rm/shift_in (request, taken when idle), write/wnum/wdata (register write),
//        busy, out_valid/out_ready (handshake), a_out (ALU A), b_out/shift_out (shifter in/shift)
// OPERAND_FETCH_BYPASS_EN: write-first forwarding on read/write collisions (see regfile)
module operand_fetch import srm_pkg::*; (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [REG_IDX_W-1:0] rn,
    input  logic [REG_IDX_W-1:0] rm,
    input  logic [1:0]           shift_in,
    input  logic                 write,
    input  logic [REG_IDX_W-1:0] wnum,
    input  logic [DATA_W-1:0]    wdata,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    a_out,
    output logic [DATA_W-1:0]    b_out,
    output logic [1:0]           shift_out
);
    state_t               state;
    logic [REG_IDX_W-1:0] rn_q, rm_q;
    logic [1:0]           shift_q;
    logic [DATA_W-1:0]    rdata;
    regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .write (write),
        .wnum  (wnum),
        .wdata (wdata),
        .rnum  (state == RD_B ? rm_q : rn_q),
        .rdata (rdata)
    );
    assign busy      = state != IDLE;
    assign out_valid = state == VALID;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rn_q      <= '0;
            rm_q      <= '0;
            shift_q   <= '0;
            a_out     <= '0;
            b_out     <= '0;
            shift_out <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    rn_q    <= rn;
                    rm_q    <= rm;
                    shift_q <= shift_in;
                    state   <= RD_A;
                end
                RD_A: begin
                    a_out <= rdata;
                    state <= RD_B;
                end
                RD_B: begin
                    b_out     <= rdata;
                    shift_out <= shift_q;
                    state     <= VALID;
                end
                default: if (out_ready) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: scoreboard bench for operand_fetch
module tb_operand_fetch;
    import srm_pkg::*;
    logic        clk = 0, reset, start, write, out_ready, busy, out_valid;
    logic [2:0]  rn, rm, wnum;
    logic [1:0]  shift_in, shift_out;
    logic [15:0] wdata, a_out, b_out;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  sh;
    } exp_t;
    exp_t        sb[$];
    logic [15:0] model [8];
    int          tests = 0, fails = 0;

    operand_fetch dut (
        .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm), .shift_in(shift_in),
        .write(write), .wnum(wnum), .wdata(wdata), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .a_out(a_out), .b_out(b_out), .shift_out(shift_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] shifter(input logic [15:0] v, input logic [1:0] s);
        case (s)
            SH_PASS: return v;
            SH_LSL:  return {v[14:0], 1'b0};
            SH_LSR:  return {1'b0, v[15:1]};
            default: return {v[15], v[15:1]};
        endcase
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] i, input logic [15:0] d);
        write = 1; wnum = i; wdata = d;
        step();
        write = 0;
        model[i] = d;
    endtask

    task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL issue_idle: busy=%b required 0", busy);
        end
        start = 1; rn = a; rm = b; shift_in = s;
        step();
        start = 0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 10) begin
            step();
            cyc++;
        end
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL valid_timeout: out_valid=%b after %0d cycles, required 1", out_valid, cyc);
        end
    endtask

    task automatic check_pop(input string name);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s_sb_empty: output with no expected entry", name);
            return;
        end
        e = sb.pop_front();
        if (a_out !== e.a) begin
            fails++;
            $display("FAIL %s_a: got %h required %h", name, a_out, e.a);
        end
        tests++;
        if (b_out !== e.b) begin
            fails++;
            $display("FAIL %s_b: got %h required %h", name, b_out, e.b);
        end
        tests++;
        if (shift_out !== e.sh) begin
            fails++;
            $display("FAIL %s_shift: got %b required %b", name, shift_out, e.sh);
        end
    endtask

    task automatic release_out(input string name);
        out_ready = 1;
        step();
        out_ready = 0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_release: out_valid=%b busy=%b required 0 0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset;
        int cyc;
        reset = 1; write = 1; wnum = 0; wdata = 16'hFFFF;
        step();
        step();
        reset = 0; write = 0;
        for (int i = 0; i < 8; i++) model[i] = '0;
        tests++;
        if (busy !== 0 || out_valid !== 0 || a_out !== 0 || b_out !== 0 || shift_out !== 0) begin
            fails++;
            $display("FAIL reset_state: busy=%b valid=%b a=%h b=%h sh=%b required all 0",
                     busy, out_valid, a_out, b_out, shift_out);
        end
        issue(0, 6, 2'b10);
        sb.push_back('{model[0], model[6], 2'b10});
        wait_valid(cyc);
        check_pop("reset_fetch");
        release_out("reset_fetch");
    endtask

    task automatic test_basic;
        int cyc;
        do_write(3, 16'hF0CF);
        do_write(5, 16'h1249);
        issue(3, 5, 2'b01);
        sb.push_back('{model[3], model[5], 2'b01});
        wait_valid(cyc);
        tests++;
        if (cyc != 3) begin
            fails++;
            $display("FAIL basic_latency: got %0d cycles required 3", cyc);
        end
        check_pop("basic");
        tests++;
        if (shifter(b_out, shift_out) !== 16'h2492) begin
            fails++;
            $display("FAIL basic_shifter: got %h required 2492", shifter(b_out, shift_out));
        end
        release_out("basic");
    endtask

    task automatic test_collision;
        int cyc;
        logic [15:0] ea;
        issue(2, 3, 2'b00);
        write = 1; wnum = 2; wdata = 16'hABCD;
        step();
        write = 0;
`ifdef OPERAND_FETCH_BYPASS_EN
        ea = 16'hABCD;
`else
        ea = model[2];
`endif
        model[2] = 16'hABCD;
        sb.push_back('{ea, model[3], 2'b00});
        wait_valid(cyc);
        check_pop("collision");
        release_out("collision");
        issue(2, 2, 2'b10);
        sb.push_back('{model[2], model[2], 2'b10});
        wait_valid(cyc);
        check_pop("collision_after");
        release_out("collision_after");
    endtask

    task automatic test_hold;
        int cyc;
        do_write(4, 16'h8001);
        do_write(6, 16'h0F0F);
        issue(4, 6, 2'b11);
        sb.push_back('{model[4], model[6], 2'b11});
        wait_valid(cyc);
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            start = 1; rn = 0; rm = 1; shift_in = 2'b01;
            step();
            tests++;
            if (out_valid !== 1 || busy !== 1 || a_out !== 16'h8001 || b_out !== 16'h0F0F || shift_out !== 2'b11) begin
                fails++;
                $display("FAIL hold_%0d: valid=%b busy=%b a=%h b=%h sh=%b required 1 1 8001 0f0f 11",
                         i, out_valid, busy, a_out, b_out, shift_out);
            end
        end
        check_pop("hold");
        out_ready = 1;
        step();
        out_ready = 0;
        start = 0;
        tests++;
        if (out_valid !== 0 || busy !== 0) begin
            fails++;
            $display("FAIL hold_release: valid=%b busy=%b required 0 0", out_valid, busy);
        end
        step();
        tests++;
        if (busy !== 0) begin
            fails++;
            $display("FAIL hold_no_new_fetch: busy=%b required 0", busy);
        end
    endtask

    task automatic test_same_reg;
        int cyc;
        do_write(7, 16'h7FFF);
        issue(7, 7, 2'b11);
        sb.push_back('{model[7], model[7], 2'b11});
        wait_valid(cyc);
        check_pop("same_reg");
        tests++;
        if (shifter(b_out, shift_out) !== 16'h3FFF) begin
            fails++;
            $display("FAIL same_reg_shifter: got %h required 3fff", shifter(b_out, shift_out));
        end
        release_out("same_reg");
    endtask

    task automatic test_reset_rd_b;
        int cyc;
        do_write(1, 16'h5555);
        issue(1, 1, 2'b01);
        step();
        reset = 1; write = 1; wnum = 1; wdata = 16'h1234;
        step();
        reset = 0; write = 0;
        for (int i = 0; i < 8; i++) model[i] = '0;
        tests++;
        if (busy !== 0 || out_valid !== 0 || a_out !== 0 || b_out !== 0 || shift_out !== 0) begin
            fails++;
            $display("FAIL rdb_reset_state: busy=%b valid=%b a=%h b=%h sh=%b required all 0",
                     busy, out_valid, a_out, b_out, shift_out);
        end
        issue(1, 3, 2'b00);
        sb.push_back('{model[1], model[3], 2'b00});
        wait_valid(cyc);
        check_pop("rdb_after");
        release_out("rdb_after");
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [2:0] a, b;
        logic [1:0] s;
        for (int i = 0; i < 6; i++) begin
            do_write(3'($urandom_range(0, 7)), 16'($urandom));
            do_write(3'($urandom_range(0, 7)), 16'($urandom));
            a = 3'($urandom_range(0, 7));
            b = 3'($urandom_range(0, 7));
            s = 2'($urandom_range(0, 3));
            issue(a, b, s);
            sb.push_back('{model[a], model[b], s});
            wait_valid(cyc);
            check_pop("b2b");
            release_out("b2b");
        end
    endtask

    initial begin
        start = 0; write = 0; out_ready = 0; rn = 0; rm = 0; shift_in = 0; wnum = 0; wdata = 0;
        reset = 1;
        test_reset();
        test_basic();
        test_collision();
        test_hold();
        test_same_reg();
        test_reset_rd_b();
        test_back_to_back();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d entries required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
